// File: rtl/cve2_obi_arbiter.sv
// cve2_obi_arbiter
//   Two-to-one OBI arbiter. It merges the core fetch port (instr_*) and the
//   LSU port (data_*) onto one shared memory master port (mem_*).
//   - Arbitration is round-robin between the two sources.
//   - Once a request is presented and not yet granted, the winner is locked,
//     so the address-phase signals stay stable until the grant.
//   - A small circular FIFO records the source of each accepted request.
//     Responses are routed back in issue order with no added latency.
//
// Parameters
//   MaxOutstanding : depth of the response-routing FIFO (1..4)
//   ResetWinner    : source treated as last winner after reset (0 instr, 1 data)
//
// Ports
//   clk_i, rst_i      : clock, synchronous active-high reset
//   instr_*           : fetch-side OBI slave (read only)
//   data_*            : LSU-side OBI slave
//   mem_*             : shared OBI master
//   protocol_err_o    : sticky; a response arrived with nothing outstanding
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic        ResetWinner    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,

  output logic        protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  src_e            fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q,  cnt_d;
  logic            lock_q, lock_d;
  src_e            lock_src_q, lock_src_d;
  src_e            last_q, last_d;
  logic            perr_q, perr_d;

  src_e            winner;
  src_e            head;
  logic            full, empty;
  logic            push, pop;

  // Fullness comes from registered occupancy only, so a pop in this cycle
  // does not let a new request through until the next cycle.
  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  always_comb begin
    winner = SRC_INSTR;
    if (lock_q) begin
      winner = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      winner = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    end else if (data_req_i) begin
      winner = SRC_DATA;
    end
  end

  assign mem_req_o = (instr_req_i | data_req_i) & ~full & ~rst_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (winner == SRC_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  assign push = mem_req_o & mem_gnt_i;
  assign pop  = mem_rvalid_i & ~empty & ~rst_i;

  assign instr_gnt_o    = push & (winner == SRC_INSTR);
  assign data_gnt_o     = push & (winner == SRC_DATA);
  assign instr_rvalid_o = pop & (head == SRC_INSTR);
  assign data_rvalid_o  = pop & (head == SRC_DATA);

  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign protocol_err_o = perr_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    last_d     = last_q;
    perr_d     = perr_q;

    if (push) begin
      wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
      last_d = winner;
      lock_d = 1'b0;
    end else if (mem_req_o) begin
      lock_d     = 1'b1;
      lock_src_d = winner;
    end

    if (pop) begin
      rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
    end

    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (mem_rvalid_i && empty) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
      last_q     <= src_e'(ResetWinner);
      perr_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      last_q     <= last_d;
      perr_q     <= perr_d;
    end
  end

  // FIFO storage needs no reset; entries are only read while occupied.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// Directed testbench for cve2_obi_arbiter (MaxOutstanding=2, ResetWinner=0).
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
// unit later, well before the next rising edge.
module tb_cve2_obi_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        perr;

  int checks   = 0;
  int failures = 0;

  cve2_obi_arbiter #(
    .MaxOutstanding (2),
    .ResetWinner    (1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_req_i    (instr_req),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_addr_i   (instr_addr),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_gnt_i      (mem_gnt),
    .mem_rvalid_i   (mem_rvalid),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .mem_err_i      (mem_err),
    .protocol_err_o (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle 1 unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    instr_addr = 32'h0; data_addr = 32'h0; data_we = 1'b0; data_be = 4'h0;
    data_wdata = 32'h0; mem_rdata = 32'h0; mem_err = 1'b0;
    #1; step();
    #1;
    chk("rst_mem_req",    {31'd0, mem_req},      32'd0);
    chk("rst_instr_gnt",  {31'd0, instr_gnt},    32'd0);
    chk("rst_data_gnt",   {31'd0, data_gnt},     32'd0);
    chk("rst_instr_rv",   {31'd0, instr_rvalid}, 32'd0);
    chk("rst_data_rv",    {31'd0, data_rvalid},  32'd0);
    chk("rst_perr",       {31'd0, perr},         32'd0);
    step();
    rst = 1'b0; instr_req = 1'b0; data_req = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk("idle_mem_req",   {31'd0, mem_req},      32'd0);

    // Single instruction fetch and its response.
    instr_req = 1'b1; instr_addr = 32'h100; data_addr = 32'hAAAA_0000;
    data_we = 1'b1; data_be = 4'h3; data_wdata = 32'h1234_5678;
    #1;
    chk("if_mem_req",     {31'd0, mem_req},   32'd1);
    chk("if_addr",        mem_addr,           32'h100);
    chk("if_be",          {28'd0, mem_be},    32'hF);
    chk("if_we",          {31'd0, mem_we},    32'd0);
    chk("if_wdata",       mem_wdata,          32'h0);
    chk("if_instr_gnt",   {31'd0, instr_gnt}, 32'd1);
    chk("if_data_gnt",    {31'd0, data_gnt},  32'd0);
    step();
    instr_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("if_instr_rv",    {31'd0, instr_rvalid}, 32'd1);
    chk("if_rdata",       instr_rdata,           32'hDEAD_BEEF);
    chk("if_data_rv",     {31'd0, data_rvalid},  32'd0);
    step();
    mem_rvalid = 1'b0;

    // Round-robin from reset (last winner = instr): data, instr, data, instr.
    rst = 1'b1; step(); rst = 1'b0;
    instr_req = 1'b1; data_req = 1'b1; instr_addr = 32'h1000; data_addr = 32'h2000;
    #1;
    chk("rr1_data_gnt",   {31'd0, data_gnt},  32'd1);
    chk("rr1_instr_gnt",  {31'd0, instr_gnt}, 32'd0);
    chk("rr1_addr",       mem_addr,           32'h2000);
    step();
    mem_rvalid = 1'b1; #1;
    chk("rr2_instr_gnt",  {31'd0, instr_gnt},   32'd1);
    chk("rr2_addr",       mem_addr,             32'h1000);
    chk("rr2_data_rv",    {31'd0, data_rvalid}, 32'd1);
    step();
    chk("rr3_data_gnt",   {31'd0, data_gnt},     32'd1);
    chk("rr3_instr_rv",   {31'd0, instr_rvalid}, 32'd1);
    step();
    chk("rr4_instr_gnt",  {31'd0, instr_gnt},   32'd1);
    chk("rr4_data_rv",    {31'd0, data_rvalid}, 32'd1);
    step();
    instr_req = 1'b0; data_req = 1'b0; #1;
    chk("rr_drain_i_rv",  {31'd0, instr_rvalid}, 32'd1);
    step();
    mem_rvalid = 1'b0;

    // One data access so that data is the last winner.
    data_req = 1'b1; data_addr = 32'h3000; #1;
    chk("pre_data_gnt",   {31'd0, data_gnt}, 32'd1);
    step();
    data_req = 1'b0; mem_rvalid = 1'b1; #1;
    chk("pre_data_rv",    {31'd0, data_rvalid}, 32'd1);
    step();
    mem_rvalid = 1'b0;

    // Lock: data held without grant for 3 cycles; instr arrives in cycle 2.
    data_req = 1'b1; data_addr = 32'h200; data_we = 1'b1; data_be = 4'h3;
    data_wdata = 32'h55; instr_addr = 32'h300; mem_gnt = 1'b0; #1;
    chk("lk1_addr",       mem_addr,          32'h200);
    chk("lk1_data_gnt",   {31'd0, data_gnt}, 32'd0);
    step();
    instr_req = 1'b1; #1;
    chk("lk2_addr",       mem_addr,           32'h200);
    chk("lk2_we",         {31'd0, mem_we},    32'd1);
    chk("lk2_instr_gnt",  {31'd0, instr_gnt}, 32'd0);
    step();
    chk("lk3_addr",       mem_addr,          32'h200);
    chk("lk3_be",         {28'd0, mem_be},   32'h3);
    step();
    mem_gnt = 1'b1; #1;
    chk("lk_gnt_data",    {31'd0, data_gnt},  32'd1);
    chk("lk_gnt_instr",   {31'd0, instr_gnt}, 32'd0);
    chk("lk_gnt_addr",    mem_addr,           32'h200);
    step();
    data_req = 1'b0; #1;
    chk("lk_after_igrant", {31'd0, instr_gnt}, 32'd1);
    chk("lk_after_addr",   mem_addr,           32'h300);
    step();
    instr_req = 1'b0; mem_rvalid = 1'b1; #1;
    chk("lk_rsp1_data",   {31'd0, data_rvalid},  32'd1);
    step();
    chk("lk_rsp2_instr",  {31'd0, instr_rvalid}, 32'd1);
    step();
    mem_rvalid = 1'b0;

    // FIFO full: data then instr accepted, third request blocked.
    data_req = 1'b1; data_addr = 32'h400; #1;
    chk("ff1_data_gnt",   {31'd0, data_gnt}, 32'd1);
    step();
    data_req = 1'b0; instr_req = 1'b1; #1;
    chk("ff2_instr_gnt",  {31'd0, instr_gnt}, 32'd1);
    step();
    instr_req = 1'b0; data_req = 1'b1; #1;
    chk("ff3_mem_req",    {31'd0, mem_req},  32'd0);
    chk("ff3_data_gnt",   {31'd0, data_gnt}, 32'd0);
    step();
    mem_rvalid = 1'b1; #1;
    chk("ff4_mem_req",    {31'd0, mem_req},      32'd0);
    chk("ff4_data_rv",    {31'd0, data_rvalid},  32'd1);
    chk("ff4_instr_rv",   {31'd0, instr_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0; #1;
    chk("ff5_mem_req",    {31'd0, mem_req},  32'd1);
    chk("ff5_data_gnt",   {31'd0, data_gnt}, 32'd1);
    step();
    data_req = 1'b0; mem_rvalid = 1'b1; #1;
    chk("ff6_instr_rv",   {31'd0, instr_rvalid}, 32'd1);
    chk("ff6_data_rv",    {31'd0, data_rvalid},  32'd0);
    step();
    chk("ff7_data_rv",    {31'd0, data_rvalid},  32'd1);
    step();

    // Response with nothing outstanding: sticky protocol error.
    chk("pe_instr_rv",    {31'd0, instr_rvalid}, 32'd0);
    chk("pe_data_rv",     {31'd0, data_rvalid},  32'd0);
    step();
    mem_rvalid = 1'b0; #1;
    chk("pe_set",         {31'd0, perr}, 32'd1);
    step();
    chk("pe_held",        {31'd0, perr}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    chk("pe_cleared",     {31'd0, perr}, 32'd0);

    // Reset with one transaction outstanding discards it.
    instr_req = 1'b1; #1;
    chk("ro_instr_gnt",   {31'd0, instr_gnt}, 32'd1);
    step();
    instr_req = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    mem_rvalid = 1'b1; #1;
    chk("ro_no_rv",       {31'd0, instr_rvalid}, 32'd0);
    chk("ro_perr_before", {31'd0, perr},         32'd0);
    step();
    mem_rvalid = 1'b0; #1;
    chk("ro_perr_set",    {31'd0, perr}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
